// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester handshakes, shared transmitter port and status of uart_tx_arb
interface uart_tx_arb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       timeout_flag;
  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_busy,
    output req0_ready, req1_ready, tx_start, tx_data, grant, timeout_flag
  );
  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_busy,
    input  req0_ready, req1_ready, tx_start, tx_data, grant, timeout_flag
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester message-locked arbiter for one UART transmitter; UART_ARB_TIMEOUT_EN adds stalled-lock release
module uart_tx_arb #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset,
  uart_tx_arb_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, OWN = 2'd1, SEND = 2'd2, DRAIN = 2'd3;
  logic [1:0] state_q, state_d, grant_q, grant_d;
  logic       rr_q, rr_d, last_q, last_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       own_valid, accept, tmo;
  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("uart_tx_arb: TIMEOUT_CYCLES must be at least 1");
  end
  assign own_valid      = grant_q[1] ? bus.req1_valid : bus.req0_valid;
  assign accept         = state_q == OWN && own_valid && !bus.tx_busy;
  assign bus.req0_ready = accept && grant_q[0];
  assign bus.req1_ready = accept && grant_q[1];
  assign bus.tx_start   = state_q == SEND;
  assign bus.tx_data    = tx_data_q;
  assign bus.grant      = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  assign tmo = state_q == OWN && !own_valid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d  = (state_q == OWN && !own_valid && !tmo) ? cnt_q + 1'b1 : '0;
    flag_d = tmo;
  end
  always_ff @(posedge clk) begin
    cnt_q  <= reset ? '0 : cnt_d;
    flag_q <= reset ? 1'b0 : flag_d;
  end
  assign bus.timeout_flag = flag_q;
`else
  assign tmo              = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (bus.req0_valid || bus.req1_valid) begin
        grant_d = (bus.req0_valid && bus.req1_valid) ? (rr_q ? 2'b10 : 2'b01)
                                                     : {bus.req1_valid, bus.req0_valid};
        state_d = OWN;
      end
      OWN: if (tmo) begin
        grant_d = 2'b00;
        rr_d    = grant_q[0];
        state_d = IDLE;
      end else if (accept) begin
        tx_data_d = grant_q[1] ? bus.req1_data : bus.req0_data;
        last_d    = grant_q[1] ? bus.req1_last : bus.req0_last;
        state_d   = SEND;
      end
      SEND: state_d = DRAIN;
      default: if (!bus.tx_busy) begin
        state_d = last_q ? IDLE : OWN;
        grant_d = last_q ? 2'b00 : grant_q;
        rr_d    = last_q ? grant_q[0] : rr_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      rr_q      <= 1'b0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized and directed checks of uart_tx_arb against a cycle-level reference model
module tb_uart_tx_arb;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arb_if bus();
  uart_tx_arb #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [8:0] q0[$], q1[$];
  bit en0 = 1'b1, en1 = 1'b1, ext_hold = 1'b0, cmp_en = 1'b0;
  int busy_left = 0, tx_len = 10;
  logic [1:0] gq[$], log_own[$];
  logic sq[$], fq[$];
  logic [7:0] log_dat[$];
  logic v0, v1, l0, l1, b;
  logic [7:0] d0, d1;
  int m_owner = -1, m_idle = 0;
  bit m_pulse = 0, m_wait = 0, m_last = 0, m_rr = 0, m_flag = 0;
  logic [7:0] m_data = 8'h00;
  logic [1:0] eo[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [7:0] ed30[4] = '{8'h01, 8'h11, 8'h02, 8'h12};
  logic [7:0] ed31[4] = '{8'h30, 8'h31, 8'h32, 8'h70};
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction
  task automatic step(input bit rst_in);
    bit in_own, ov, nf;
    @(negedge clk);
    reset = rst_in;
    v0 = q0.size() > 0 && en0;
    v1 = q1.size() > 0 && en1;
    {l0, d0} = 9'h000;
    {l1, d1} = 9'h000;
    if (v0) {l0, d0} = q0[0];
    if (v1) {l1, d1} = q1[0];
    b = busy_left > 0 || ext_hold;
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_last = l1;
    bus.tx_busy = b;
    #1;
    if (cmp_en) begin
      in_own = m_owner >= 0 && !m_pulse && !m_wait;
      check("grant", 32'(bus.grant), m_owner < 0 ? 0 : (1 << m_owner));
      check("req0_ready", 32'(bus.req0_ready), 32'(in_own && m_owner == 0 && v0 && !b));
      check("req1_ready", 32'(bus.req1_ready), 32'(in_own && m_owner == 1 && v1 && !b));
      check("tx_start", 32'(bus.tx_start), 32'(m_pulse));
      check("tx_data", 32'(bus.tx_data), 32'(m_data));
      check("timeout_flag", 32'(bus.timeout_flag), 32'(m_flag));
    end
    gq.push_back(bus.grant);
    sq.push_back(bus.tx_start);
    fq.push_back(bus.timeout_flag);
    if (bus.tx_start === 1'b1) begin
      log_dat.push_back(bus.tx_data);
      log_own.push_back(bus.grant);
    end
    if (bus.req0_ready === 1'b1 && q0.size() > 0) void'(q0.pop_front());
    if (bus.req1_ready === 1'b1 && q1.size() > 0) void'(q1.pop_front());
    if (busy_left > 0) busy_left--;
    if (bus.tx_start === 1'b1) busy_left = tx_len;
    nf = 1'b0;
    if (m_owner < 0) begin
      m_idle = 0;
      if (v0 || v1) m_owner = (v0 && v1) ? int'(m_rr) : (v0 ? 0 : 1);
    end else if (m_pulse) begin
      m_pulse = 1'b0;
      m_wait = 1'b1;
    end else if (m_wait) begin
      if (!b) begin
        m_wait = 1'b0;
        if (m_last) begin
          m_rr = m_owner == 0;
          m_owner = -1;
        end
      end
    end else begin
      ov = m_owner == 1 ? v1 : v0;
      if (ov && !b) begin
        m_data = m_owner == 1 ? d1 : d0;
        m_last = m_owner == 1 ? l1 : l0;
        m_pulse = 1'b1;
        m_idle = 0;
      end else if (ov) begin
        m_idle = 0;
      end else begin
        m_idle++;
`ifdef UART_ARB_TIMEOUT_EN
        if (m_idle == TMO) begin
          m_rr = m_owner == 0;
          m_owner = -1;
          m_idle = 0;
          nf = 1'b1;
        end
`endif
      end
    end
    m_flag = nf;
    if (rst_in) begin
      m_owner = -1; m_pulse = 0; m_wait = 0; m_last = 0; m_rr = 0; m_flag = 0; m_idle = 0;
      m_data = 8'h00;
    end
    cyc++;
  endtask
  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (log_dat.size() < n && k < budget) begin
      step(1'b0);
      k++;
    end
    check("start_budget", 32'(log_dat.size()), 32'(n));
  endtask
  function automatic int starts_in(int a, int z);
    int c = 0;
    for (int i = a; i <= z; i++) c += int'(sq[i] === 1'b1);
    return c;
  endfunction
  initial begin
    int t0, t1, base;
    step(1'b1);
    cmp_en = 1'b1;
    step(1'b0);
    t0 = cyc;
    q0.push_back({1'b1, 8'h41});
    repeat (16) step(1'b0);
    check("t29_grant_n1", 32'(gq[t0+1]), 32'h1);
    check("t29_start_n1", 32'(sq[t0+1]), 32'h0);
    check("t29_start_n2", 32'(sq[t0+2]), 32'h1);
    check("t29_starts", 32'(starts_in(t0, t0 + 15)), 32'h1);
    check("t29_data", 32'(log_dat[0]), 32'h41);
    check("t29_grant_held", 32'(gq[t0+13]), 32'h1);
    check("t29_grant_drop", 32'(gq[t0+14]), 32'h0);
    t1 = cyc;
    base = log_dat.size();
    q0.push_back({1'b1, 8'h50});
    q1.push_back({1'b1, 8'h60});
    run_until(base + 2, 100);
    check("t29_rr_owner", 32'(gq[t1+1]), 32'h2);
    check("t29_rr_data", 32'(log_dat[base]), 32'h60);
    step(1'b1);
    base = log_dat.size();
    q0.push_back({1'b1, 8'h01}); q0.push_back({1'b1, 8'h02});
    q1.push_back({1'b1, 8'h11}); q1.push_back({1'b1, 8'h12});
    run_until(base + 4, 200);
    for (int i = 0; i < 4 && base + i < log_dat.size(); i++) begin
      check("t30_owner", 32'(log_own[base+i]), 32'(eo[i]));
      check("t30_data", 32'(log_dat[base+i]), 32'(ed30[i]));
    end
    step(1'b1);
    base = log_dat.size();
    q0.push_back({1'b0, 8'h30}); q0.push_back({1'b0, 8'h31}); q0.push_back({1'b1, 8'h32});
    q1.push_back({1'b1, 8'h70});
    run_until(base + 4, 200);
    for (int i = 0; i < 4 && base + i < log_dat.size(); i++)
      check("t31_order", 32'(log_dat[base+i]), 32'(ed31[i]));
    repeat (15) step(1'b0);
    step(1'b1);
    ext_hold = 1'b1;
    t0 = cyc;
    base = log_dat.size();
    q0.push_back({1'b1, 8'h5A});
    repeat (8) step(1'b0);
    check("t32_grant", 32'(gq[t0+1]), 32'h1);
    check("t32_no_start", 32'(starts_in(t0, t0 + 7)), 32'h0);
    check("t32_held", 32'(q0.size()), 32'h1);
    ext_hold = 1'b0;
    t1 = cyc;
    repeat (3) step(1'b0);
    check("t32_start", 32'(sq[t1+1]), 32'h1);
    check("t32_data", 32'(log_dat.size() > base ? log_dat[base] : 8'h00), 32'h5A);
    repeat (15) step(1'b0);
    step(1'b1);
    base = log_dat.size();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'hB1});
    run_until(base + 1, 50);
    repeat (2) step(1'b0);
    q0.delete();
    t1 = cyc;
    step(1'b1);
    repeat (20) step(1'b0);
    check("t33_grant_clear", 32'(gq[t1+1]), 32'h0);
    check("t33_grant_req1", 32'(gq[t1+2]), 32'h2);
    check("t33_starts", 32'(log_dat.size()), 32'(base + 2));
    check("t33_data", 32'(log_dat.size() > base + 1 ? log_dat[base+1] : 8'h00), 32'hB1);
    repeat (15) step(1'b0);
    step(1'b1);
    t0 = cyc;
    q0.push_back({1'b0, 8'hC1});
    q1.push_back({1'b1, 8'hD1});
`ifdef UART_ARB_TIMEOUT_EN
    repeat (40) step(1'b0);
    check("t34_held", 32'(gq[t0+14+15]), 32'h1);
    check("t34_release", 32'(gq[t0+14+16]), 32'h0);
    check("t34_flag", 32'(fq[t0+14+16]), 32'h1);
    check("t34_flag_once", 32'(fq[t0+14+17]), 32'h0);
    check("t34_req1", 32'(gq[t0+14+17]), 32'h2);
`else
    repeat (60) step(1'b0);
    check("t34_locked", 32'(gq[cyc-1]), 32'h1);
    check("t34_req1_wait", 32'(q1.size()), 32'h1);
`endif
    step(1'b1);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        int n = $urandom_range(1, 4);
        bit w = $urandom_range(0, 1);
        if ((w ? q1.size() : q0.size()) < 6)
          for (int j = 0; j < n; j++) begin
            logic [8:0] e = {1'(j == n - 1), 8'($urandom)};
            if (w) q1.push_back(e); else q0.push_back(e);
          end
      end
      en0 = $urandom_range(0, 3) != 0;
      en1 = $urandom_range(0, 3) != 0;
      tx_len = $urandom_range(1, 12);
      step($urandom_range(0, 599) == 0);
    end
    en0 = 1'b1;
    en1 = 1'b1;
    for (int k = 0; k < 3000 && (q0.size() > 0 || q1.size() > 0 || m_owner >= 0); k++)
      step(1'b0);
    check("drain_q0", 32'(q0.size()), 32'h0);
    check("drain_q1", 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: idle cycles before a stalled locked requester is released (used only when UART_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a byte on req0_data.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_last  input  1  byte on req0_data ends requester 0's message (release lock after it).
REQ-007 req0_ready  output  1  byte accepted from requester 0 this cycle.
REQ-008 req1_valid / req1_data / req1_last / req1_ready  same widths and meaning for requester 1.
REQ-009 tx_start  output  1  one-cycle pulse: transmitter loads tx_data.
REQ-010 tx_data  output  8  byte to the shared UART transmitter.
REQ-011 tx_busy  input  1  transmitter busy; contract: high from the cycle after tx_start until the stop bit completes.
REQ-012 grant  output  2  one-hot current owner (bit0 = req0, bit1 = req1), 2'b00 when unowned.
REQ-013 timeout_flag  output  1  one-cycle pulse when a lock is force-released.

Function
REQ-014 The state machine SHALL have four states: IDLE, OWN, SEND, DRAIN.
REQ-015 IDLE: only req0 valid -> owner 0; only req1 valid -> owner 1; both valid -> owner = round-robin pointer rr; next state OWN; none valid -> stay IDLE.
REQ-016 OWN: reqN_ready = 1 combinationally iff owner is N, reqN_valid = 1 and tx_busy = 0; the non-owner's ready SHALL be 0 in every state.
REQ-017 On an accepted byte (valid & ready), tx_data SHALL register reqN_data, the last flag SHALL register reqN_last, next state SEND.
REQ-018 SEND: tx_start = 1 for exactly this cycle; next state DRAIN.
REQ-019 DRAIN: hold while tx_busy = 1; on tx_busy = 0, registered last = 1 -> clear grant, rr = other requester, IDLE; last = 0 -> OWN (lock kept).
REQ-020 Latency: valid asserted in IDLE at cycle N with tx_busy = 0 -> grant at N+1, ready at N+1, tx_start at N+2.
REQ-021 tx_data SHALL remain stable from SEND until the next accepted byte.
REQ-022 A requester deasserting valid while owning (no timeout) SHALL keep the lock; the other requester SHALL wait.
REQ-023 grant SHALL change only on IDLE->OWN and DRAIN->IDLE transitions (and on timeout release).
REQ-024 At most one tx_start SHALL be issued per byte; no tx_start while tx_busy = 1.

Reset
REQ-025 reset = 1 at a rising edge SHALL force state IDLE, grant = 2'b00, tx_start = 0, tx_data = 8'h00, rr = 0, timeout counter = 0, timeout_flag = 0, both ready = 0 from the next cycle.
REQ-026 Reset mid-message SHALL drop the lock and any registered byte not yet pulsed; a byte already in the transmitter is not aborted by this block.

Configuration
REQ-027 Macro UART_ARB_TIMEOUT_EN defined: in OWN, a counter SHALL count consecutive cycles with owner valid = 0; at TIMEOUT_CYCLES it SHALL release the lock (grant 2'b00, rr = other, IDLE) and pulse timeout_flag for one cycle; counter clears on any owner valid or state change.
REQ-028 Macro undefined: no counter logic, lock held indefinitely, timeout_flag tied 0.

Verification
REQ-029 Single byte: req0 sends 8'h41 last=1, tx_busy model 10 cycles -> tx_start once with tx_data 8'h41, grant 01 then 00, rr = 1.
REQ-030 Contention: req0 and req1 valid in same IDLE cycle after reset -> req0 served first; repeated -> owners alternate 0,1,0,1.
REQ-031 Message lock: req0 sends 8'h30,8'h31,8'h32 (last on 8'h32) while req1 valid throughout -> all three transmitted contiguously before any req1 byte.
REQ-032 Backpressure: tx_busy held high externally in OWN -> ready stays 0, no tx_start until tx_busy falls.
REQ-033 Reset in DRAIN of a non-last byte -> next cycle grant 00, IDLE, no further tx_start; req1 then granted normally.
REQ-034 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16: req0 sends non-last byte then drops valid -> release and timeout_flag pulse exactly 16 cycles after OWN re-entry; req1 granted next cycle; without macro, req1 never granted.
